// File: rtl/keycode_dir_ctrl.sv
// keycode_dir_ctrl: filters the SoC HID keycode and turns accepted key presses
// into Pac-Man direction, buffered turn request, pause toggle and start pulse.
module keycode_dir_ctrl #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_FRAMES = 60
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       turn_accept,
    output logic [1:0] cur_dir,
    output logic [1:0] next_dir,
    output logic       next_valid,
    output logic       pause,
    output logic       start_pulse,
    output logic       key_held
);
    localparam int unsigned KEY_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIR_W = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [KEY_W-1:0] KEY_NONE  = 8'h00;
    localparam logic [KEY_W-1:0] KEY_W_UP  = 8'h1A;
    localparam logic [KEY_W-1:0] KEY_A_LT  = 8'h04;
    localparam logic [KEY_W-1:0] KEY_S_DN  = 8'h16;
    localparam logic [KEY_W-1:0] KEY_D_RT  = 8'h07;
    localparam logic [KEY_W-1:0] KEY_AR_UP = 8'h52;
    localparam logic [KEY_W-1:0] KEY_AR_LT = 8'h50;
    localparam logic [KEY_W-1:0] KEY_AR_DN = 8'h51;
    localparam logic [KEY_W-1:0] KEY_AR_RT = 8'h4F;
    localparam logic [KEY_W-1:0] KEY_SPACE = 8'h2C;
    localparam logic [KEY_W-1:0] KEY_ENTER = 8'h28;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;
    localparam logic [DIR_W-1:0] DIR_FLIP  = 2'b10;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TCNT_LAST  = CNT_W'(TIMEOUT_FRAMES - 1);

    // Direction lookup; valid only when key_is_dir() is true.
    function automatic logic [DIR_W-1:0] key_dir(input logic [KEY_W-1:0] k);
        logic [DIR_W-1:0] d;
        d = DIR_UP;
        case (k)
            KEY_W_UP, KEY_AR_UP: d = DIR_UP;
            KEY_A_LT, KEY_AR_LT: d = DIR_LEFT;
            KEY_S_DN, KEY_AR_DN: d = DIR_DOWN;
            KEY_D_RT, KEY_AR_RT: d = DIR_RIGHT;
            default:             d = DIR_UP;
        endcase
        return d;
    endfunction

    function automatic logic key_is_dir(input logic [KEY_W-1:0] k);
        logic r;
        r = 1'b0;
        case (k)
            KEY_W_UP, KEY_AR_UP, KEY_A_LT, KEY_AR_LT,
            KEY_S_DN, KEY_AR_DN, KEY_D_RT, KEY_AR_RT: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    logic [0:0]       state, state_d;
    logic [KEY_W-1:0] kq, ks, ks_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] tcnt, tcnt_d;
    logic [DIR_W-1:0] cur_dir_d, next_dir_d;
    logic             next_valid_d, pause_d, start_pulse_d, key_held_d;

    logic             key_ev_c;
    logic             dir_ev_c;
    logic [DIR_W-1:0] ev_dir_c;

    // An event fires once per change of the accepted (stable) key.
    assign key_ev_c = (cnt == STABLE_MAX) && (kq != ks);
    assign dir_ev_c = key_ev_c && key_is_dir(kq);
    assign ev_dir_c = key_dir(kq);

    always_comb begin
        state_d       = state;
        ks_d          = ks;
        cnt_d         = cnt;
        tcnt_d        = tcnt;
        cur_dir_d     = cur_dir;
        next_dir_d    = next_dir;
        pause_d       = pause;
        start_pulse_d = 1'b0;
        key_held_d    = key_held;

        if (keycode != kq) begin
            cnt_d = '0;
        end else if (cnt != STABLE_MAX) begin
            cnt_d = cnt + CNT_W'(1);
        end

        if (key_ev_c) begin
            ks_d       = kq;
            key_held_d = key_is_dir(kq);
            if (kq == KEY_SPACE) begin
                pause_d = ~pause;
            end
            if (kq == KEY_ENTER) begin
                start_pulse_d = 1'b1;
            end
        end

        // Direction event outranks turn_accept, which outranks timeout.
        if (dir_ev_c && !pause) begin
            if (ev_dir_c == cur_dir) begin
                state_d = ST_IDLE;
            end else if (ev_dir_c == (cur_dir ^ DIR_FLIP)) begin
                cur_dir_d = ev_dir_c;
                state_d   = ST_IDLE;
            end else begin
                next_dir_d = ev_dir_c;
                tcnt_d     = '0;
                state_d    = ST_PEND;
            end
        end else if (state == ST_PEND) begin
            if (turn_accept) begin
                cur_dir_d = next_dir;
                state_d   = ST_IDLE;
            end else if (frame_tick && !pause) begin
                if (tcnt == TCNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt + CNT_W'(1);
                end
            end
        end

        next_valid_d = (state_d == ST_PEND);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= ST_IDLE;
            kq          <= KEY_NONE;
            ks          <= KEY_NONE;
            cnt         <= '0;
            tcnt        <= '0;
            cur_dir     <= DIR_LEFT;
            next_dir    <= DIR_UP;
            next_valid  <= 1'b0;
            pause       <= 1'b0;
            start_pulse <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            state       <= state_d;
            kq          <= keycode;
            ks          <= ks_d;
            cnt         <= cnt_d;
            tcnt        <= tcnt_d;
            cur_dir     <= cur_dir_d;
            next_dir    <= next_dir_d;
            next_valid  <= next_valid_d;
            pause       <= pause_d;
            start_pulse <= start_pulse_d;
            key_held    <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keycode_dir_ctrl.sv
// Directed bench for keycode_dir_ctrl: filter latency, glitch rejection,
// turn buffering, timeout, pause/start and asynchronous reset.
module tb_keycode_dir_ctrl;
    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       turn_accept;
    logic [1:0] cur_dir;
    logic [1:0] next_dir;
    logic       next_valid;
    logic       pause;
    logic       start_pulse;
    logic       key_held;

    int checks   = 0;
    int failures = 0;

    keycode_dir_ctrl #(.STABLE_CYCLES(4), .TIMEOUT_FRAMES(60)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .keycode      (keycode),
        .frame_tick   (frame_tick),
        .turn_accept  (turn_accept),
        .cur_dir      (cur_dir),
        .next_dir     (next_dir),
        .next_valid   (next_valid),
        .pause        (pause),
        .start_pulse  (start_pulse),
        .key_held     (key_held)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each step lets one rising edge pass; inputs and samples sit on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic press(input logic [7:0] code);
        keycode = code;
        step(6);
    endtask

    task automatic accept_pulse();
        turn_accept = 1'b1;
        step(1);
        turn_accept = 1'b0;
    endtask

    task automatic tick_pulse();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
    endtask

    initial begin
        reset_reset_n = 1'b0;
        keycode       = 8'h00;
        frame_tick    = 1'b0;
        turn_accept   = 1'b0;
        step(2);
        check_eq("rst_cur_dir",    32'(cur_dir),     32'h1);
        check_eq("rst_next_dir",   32'(next_dir),    32'h0);
        check_eq("rst_next_valid", 32'(next_valid),  32'h0);
        check_eq("rst_pause",      32'(pause),       32'h0);
        check_eq("rst_start",      32'(start_pulse), 32'h0);
        check_eq("rst_key_held",   32'(key_held),    32'h0);
        reset_reset_n = 1'b1;
        step(2);

        // D from left is the opposite direction: immediate reversal, 6th edge.
        keycode = 8'h07;
        step(5);
        check_eq("lat_cur_before", 32'(cur_dir), 32'h1);
        step(1);
        check_eq("lat_cur_after",  32'(cur_dir),    32'h3);
        check_eq("rev_next_valid", 32'(next_valid), 32'h0);
        check_eq("rev_key_held",   32'(key_held),   32'h1);
        step(4);
        check_eq("hold_cur",       32'(cur_dir),    32'h3);
        press(8'h00);
        check_eq("release_held",   32'(key_held),   32'h0);

        // Up from right is a turn: buffered, then committed by turn_accept.
        press(8'h1A);
        check_eq("up_next_dir",    32'(next_dir),   32'h0);
        check_eq("up_next_valid",  32'(next_valid), 32'h1);
        check_eq("up_cur_kept",    32'(cur_dir),    32'h3);
        accept_pulse();
        check_eq("acc_cur_dir",    32'(cur_dir),    32'h0);
        check_eq("acc_next_valid", 32'(next_valid), 32'h0);
        press(8'h00);
        accept_pulse();
        check_eq("idle_acc_cur",   32'(cur_dir),    32'h0);
        check_eq("idle_acc_valid", 32'(next_valid), 32'h0);

        // Fast toggling never settles long enough to be accepted.
        for (int i = 0; i < 25; i++) begin
            keycode = (i % 2 == 0) ? 8'h1A : 8'h00;
            step(2);
        end
        keycode = 8'h00;
        step(1);
        check_eq("glitch_key_held", 32'(key_held),   32'h0);
        check_eq("glitch_valid",    32'(next_valid), 32'h0);

        // A 4-cycle pulse of Down is rejected; a 5-cycle pulse is accepted.
        keycode = 8'h16;
        step(4);
        keycode = 8'h00;
        step(8);
        check_eq("glitch4_cur",  32'(cur_dir),  32'h0);
        check_eq("glitch4_held", 32'(key_held), 32'h0);
        keycode = 8'h16;
        step(5);
        keycode = 8'h00;
        step(1);
        check_eq("glitch5_cur",  32'(cur_dir),  32'h2);
        check_eq("glitch5_held", 32'(key_held), 32'h1);
        step(7);
        check_eq("glitch5_rel",  32'(key_held), 32'h0);

        // Pending left from down expires on the 60th frame tick.
        press(8'h50);
        check_eq("to_next_dir", 32'(next_dir),   32'h1);
        check_eq("to_valid",    32'(next_valid), 32'h1);
        press(8'h00);
        for (int i = 0; i < 59; i++) tick_pulse();
        check_eq("to_59_valid", 32'(next_valid), 32'h1);
        tick_pulse();
        check_eq("to_60_valid", 32'(next_valid), 32'h0);
        check_eq("to_cur_kept", 32'(cur_dir),    32'h2);

        // Pause toggles on Space; direction keys are ignored while paused.
        press(8'h2C);
        check_eq("pause_on", 32'(pause), 32'h1);
        press(8'h00);
        press(8'h04);
        check_eq("paused_valid", 32'(next_valid), 32'h0);
        check_eq("paused_cur",   32'(cur_dir),    32'h2);
        press(8'h00);
        press(8'h2C);
        check_eq("pause_off", 32'(pause), 32'h0);
        press(8'h00);

        // Enter gives exactly one start cycle.
        keycode = 8'h28;
        step(5);
        check_eq("start_before", 32'(start_pulse), 32'h0);
        step(1);
        check_eq("start_high",   32'(start_pulse), 32'h1);
        step(1);
        check_eq("start_low",    32'(start_pulse), 32'h0);
        press(8'h00);

        // Set up right, then pend up; a new Down event beats turn_accept.
        press(8'h4F);
        accept_pulse();
        check_eq("setup_cur", 32'(cur_dir), 32'h3);
        press(8'h1A);
        check_eq("pend_up", 32'(next_valid), 32'h1);
        keycode = 8'h51;
        step(5);
        turn_accept = 1'b1;
        step(1);
        turn_accept = 1'b0;
        check_eq("prio_next_dir", 32'(next_dir),   32'h2);
        check_eq("prio_valid",    32'(next_valid), 32'h1);
        check_eq("prio_cur",      32'(cur_dir),    32'h3);

        // Asynchronous reset mid-PENDING, between clock edges.
        #2 reset_reset_n = 1'b0;
        #1;
        check_eq("arst_cur_dir",  32'(cur_dir),     32'h1);
        check_eq("arst_next_dir", 32'(next_dir),    32'h0);
        check_eq("arst_valid",    32'(next_valid),  32'h0);
        check_eq("arst_pause",    32'(pause),       32'h0);
        check_eq("arst_start",    32'(start_pulse), 32'h0);
        check_eq("arst_held",     32'(key_held),    32'h0);
        step(1);
        reset_reset_n = 1'b1;
        keycode = 8'h00;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
